// File: rtl/pipeline_mem_access_stage_pkg.sv
// Shared types for the memory-access pipeline stage: access sizes, FSM states,
// the forwarding record and the lane-index width helper.
package pipeline_mem_access_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_stage_state_t;

  // The record is sized for the widest supported configuration; stages slice it down.
  localparam int FWD_RD_MAX   = 16;
  localparam int FWD_DATA_MAX = 64;

  typedef struct packed {
    logic [FWD_RD_MAX-1:0]   rd;
    logic                    ready;
    logic [FWD_DATA_MAX-1:0] data;
  } fwd_rec_t;

  function automatic int LANE_BITS(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/pipeline_mem_access_stage_mem_lane_aligner.sv
// Combinational lane steering: store byte enables and replicated store data,
// load extraction with sign/zero extension.
module mem_lane_aligner
  import pipeline_mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int LB = LANE_BITS(DATA_WIDTH)
) (
  input  mem_size_t             size,
  input  logic                  isSigned,
  input  logic [LB-1:0]         laneOff,
  input  logic [DATA_WIDTH-1:0] storeData,
  input  logic [DATA_WIDTH-1:0] loadWord,
  output logic [NB-1:0]         byteStrobe,
  output logic [DATA_WIDTH-1:0] storeLanes,
  output logic [DATA_WIDTH-1:0] loadValue
);

  localparam int CW = LB + 2;
  localparam logic [1:0] MAX_SIZE = 2'(LB);

  logic [1:0]            sizeEff;
  logic [CW-1:0]         nBytes;
  logic [CW+2:0]         nBits;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  signBit;

  // A doubleword request on a 32-bit port degrades to a full-word access.
  assign sizeEff = (size > MAX_SIZE) ? MAX_SIZE : size;
  assign nBytes  = CW'(1) << sizeEff;
  assign nBits   = {nBytes, 3'b000};
  assign shifted = loadWord >> {laneOff, 3'b000};

  always_comb begin
    signBit = shifted[DATA_WIDTH-1];
    case (sizeEff)
      2'd0:    signBit = shifted[7];
      2'd1:    signBit = shifted[15];
      2'd2:    signBit = shifted[31];
      default: signBit = shifted[DATA_WIDTH-1];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : gLane
      logic [LB-1:0] srcIdx;
      assign byteStrobe[gi] = (CW'(gi) >= CW'(laneOff)) &&
                              (CW'(gi) < (CW'(laneOff) + nBytes));
      assign srcIdx = LB'(gi) & LB'(nBytes - 1'b1);
      assign storeLanes[8*gi +: 8] = storeData[{srcIdx, 3'b000} +: 8];
    end
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : gExt
      assign loadValue[gi] = ((CW+3)'(gi) < nBits) ? shifted[gi] : (isSigned & signBit);
    end
  endgenerate

endmodule

// File: rtl/pipeline_mem_access_stage.sv
// Memory stage between execute and writeback: req/gnt/rvalid port, upstream stall,
// registered writeback result and forwarding record. Option: MEM_ALIGN_TRAP_EN.
module pipeline_mem_access_stage
  import pipeline_mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_ID_W    = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  input  logic                    in_load,
  input  logic                    in_store,
  input  logic [1:0]              in_size,
  input  logic                    in_signed,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [RD_ID_W-1:0]      in_rd,
  input  logic                    in_rd_we,
  input  logic                    in_rd_ready,
  input  logic [DATA_WIDTH-1:0]   in_rd_data,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    out_valid,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [RD_ID_W-1:0]      out_rd,
  output logic                    out_rd_ready,
  output logic [DATA_WIDTH-1:0]   out_rd_data,
  output logic [RD_ID_W-1:0]      fwd_rd,
  output logic                    fwd_ready,
  output logic [DATA_WIDTH-1:0]   fwd_data
`ifdef MEM_ALIGN_TRAP_EN
  ,
  output logic                    out_misalign
`endif
);

  localparam int LB = LANE_BITS(DATA_WIDTH);
  localparam int NB = DATA_WIDTH / 8;

  mem_stage_state_t      state;
  logic                  memOp;
  logic                  misalign;
  logic                  trap;
  logic                  issue;
  logic                  respond;
  logic                  accept;
  logic [LB-1:0]         rawOff;
  logic [LB-1:0]         alignMask;
  logic [LB-1:0]         laneOff;
  logic [NB-1:0]         byteStrobe;
  logic [DATA_WIDTH-1:0] storeLanes;
  logic [DATA_WIDTH-1:0] loadValue;
  logic [RD_ID_W-1:0]    resRd;
  logic                  resReady;
  logic [DATA_WIDTH-1:0] resData;
  fwd_rec_t              fwdRec;
  logic                  unusedFwdBits;

  assign rawOff    = in_addr[LB-1:0];
  assign alignMask = LB'((1 << in_size) - 1);

`ifdef MEM_ALIGN_TRAP_EN
  assign misalign = (rawOff & alignMask) != '0;
  assign laneOff  = rawOff;
`else
  assign misalign = 1'b0;
  assign laneOff  = rawOff & ~alignMask;
`endif

  assign memOp   = in_valid & (in_load | in_store);
  assign trap    = memOp & misalign;
  assign issue   = memOp & ~misalign;
  assign respond = (state == ST_WAIT) & mem_rvalid;
  // A result is taken either straight from execute or when the memory responds.
  assign accept  = ((state == ST_IDLE) & in_valid & ~issue) | respond;

  // Reset is gated in so a request is withdrawn in the very cycle reset is seen.
  assign mem_req = ~reset & (((state == ST_IDLE) & issue) | (state == ST_REQ));
  assign stall   = ~reset & (((state == ST_IDLE) & issue) | (state == ST_REQ) |
                             ((state == ST_WAIT) & ~mem_rvalid));

  assign mem_we    = in_store;
  assign mem_addr  = {in_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
  assign mem_wstrb = in_store ? byteStrobe : '0;
  assign mem_wdata = storeLanes;

  mem_lane_aligner #(
    .DATA_WIDTH(DATA_WIDTH)
  ) laneAligner (
    .size      (mem_size_t'(in_size)),
    .isSigned  (in_signed),
    .laneOff   (laneOff),
    .storeData (in_wdata),
    .loadWord  (mem_rdata),
    .byteStrobe(byteStrobe),
    .storeLanes(storeLanes),
    .loadValue (loadValue)
  );

  always_comb begin
    resRd    = '0;
    resReady = 1'b1;
    resData  = '0;
    if (!trap && in_rd_we) begin
      resRd = in_rd;
      if (in_load) begin
        resData = loadValue;
      end else if (!in_store) begin
        resReady = in_rd_ready;
        resData  = in_rd_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rd       <= '0;
      out_rd_ready <= 1'b1;
      out_rd_data  <= '0;
`ifdef MEM_ALIGN_TRAP_EN
      out_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (issue) state <= mem_gnt ? ST_WAIT : ST_REQ;
        ST_REQ:  if (mem_gnt) state <= ST_WAIT;
        ST_WAIT: if (mem_rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      out_valid <= accept;
      if (accept) begin
        out_pc       <= in_pc;
        out_rd       <= resRd;
        out_rd_ready <= resReady;
        out_rd_data  <= resData;
      end else begin
        out_rd       <= '0;
        out_rd_ready <= 1'b1;
        out_rd_data  <= '0;
      end
`ifdef MEM_ALIGN_TRAP_EN
      out_misalign <= accept & trap;
`endif
    end
  end

  // Bubbles present a neutral record so hazard logic never matches them.
  always_comb begin
    fwdRec       = '0;
    fwdRec.ready = 1'b1;
    if (out_valid) begin
      fwdRec.rd    = FWD_RD_MAX'(out_rd);
      fwdRec.ready = out_rd_ready;
      fwdRec.data  = FWD_DATA_MAX'(out_rd_data);
    end
  end

  assign fwd_rd        = fwdRec.rd[RD_ID_W-1:0];
  assign fwd_ready     = fwdRec.ready;
  assign fwd_data      = fwdRec.data[DATA_WIDTH-1:0];
  assign unusedFwdBits = ^fwdRec;

endmodule
